// File: rtl/amifat_pkg.sv
// Shared types, side encodings and the arbitration decision for the amiFat arbiter.
package amifat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        GAP     = 2'd3
    } arb_state_t;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    // Pick the next owner from an idle/turnaround state; a tie goes to the side not served last.
    function automatic arb_state_t arbitrate(input logic req_a, input logic req_b, input logic last);
        arb_state_t pick;
        if (req_a && req_b) begin
            pick = (last == SIDE_A) ? GRANT_B : GRANT_A;
        end else if (req_a) begin
            pick = GRANT_A;
        end else if (req_b) begin
            pick = GRANT_B;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/amifat_hold_timer.sv
// Saturating hold-time counter: clear restarts it (at 1 when en is also set,
// i.e. on entry into a grant), en counts up and stops at MAX_HOLD.
module amifat_hold_timer #(
    parameter  int MAX_HOLD = 8,
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    // Hold-cycle count register with restart and saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= en ? CNT_W'(1) : '0;
        end else if (en && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign at_max = (cnt == CNT_W'(MAX_HOLD));

endmodule

// File: rtl/amifat_arbiter.sv
// Two-requester round-robin arbiter with bounded hold time and a one-cycle
// turnaround gap between grants. All outputs are registered.
module amifat_arbiter
    import amifat_pkg::*;
#(
    parameter  int MAX_HOLD = 8,
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic timeout
);

    arb_state_t       state;
    arb_state_t       next_state;
    logic             last;
    logic             revoke;
    logic             in_grant;
    logic             next_in_grant;
    logic             timer_clear;
    logic             timer_en;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_at_max;
    logic             hold_full;
    logic             gnt_a_nxt;
    logic             gnt_b_nxt;
    logic             busy_nxt;
    logic             timeout_nxt;

    assign in_grant      = (state == GRANT_A) || (state == GRANT_B);
    assign next_in_grant = (next_state == GRANT_A) || (next_state == GRANT_B);
    // Grants never go straight from one side to the other, so staying in a grant
    // means staying with the same owner; anything else restarts the count.
    assign timer_clear   = !(in_grant && next_in_grant);
    assign timer_en      = next_in_grant && !(in_grant && hold_at_max);
    assign hold_full     = (hold_cnt == CNT_W'(MAX_HOLD));

    amifat_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .en     (timer_en),
        .cnt    (hold_cnt),
        .at_max (hold_at_max)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: arbitration when free, release/revoke checks while granted.
    always_comb begin
        next_state = state;
        revoke     = 1'b0;
        case (state)
            IDLE, GAP: begin
                next_state = arbitrate(req_a, req_b, last);
            end
            GRANT_A: begin
                if (done_a || !req_a) begin
                    next_state = GAP;
                end else if (hold_full && req_b) begin
                    next_state = GAP;
                    revoke     = 1'b1;
                end else begin
                    next_state = GRANT_A;
                end
            end
            GRANT_B: begin
                if (done_b || !req_b) begin
                    next_state = GAP;
                end else if (hold_full && req_a) begin
                    next_state = GAP;
                    revoke     = 1'b1;
                end else begin
                    next_state = GRANT_B;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        gnt_a_nxt   = 1'b0;
        gnt_b_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        timeout_nxt = revoke;
        case (next_state)
            GRANT_A: begin
                gnt_a_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            GRANT_B: begin
                gnt_b_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            GAP: begin
                busy_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            gnt_a   <= gnt_a_nxt;
            gnt_b   <= gnt_b_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

    // Last-served side, updated whenever a grant is (re)entered; B after reset so A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= SIDE_B;
        end else if (next_state == GRANT_A) begin
            last <= SIDE_A;
        end else if (next_state == GRANT_B) begin
            last <= SIDE_B;
        end else begin
            last <= last;
        end
    end

endmodule

// File: tb/tb_amifat_arbiter.sv
// Scenario bench for amifat_arbiter: expected output words are queued as each
// cycle's stimulus is applied and compared once the clock edge has produced them.
module tb_amifat_arbiter;
    import amifat_pkg::*;

    // Output word {gnt_a, gnt_b, busy, timeout}
    localparam logic [3:0] E_IDLE = 4'b0000;
    localparam logic [3:0] E_GA   = 4'b1010;
    localparam logic [3:0] E_GB   = 4'b0110;
    localparam logic [3:0] E_GAP  = 4'b0010;
    localparam logic [3:0] E_TO   = 4'b0011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic done_a = 1'b0;
    logic done_b = 1'b0;
    logic gnt_a, gnt_b, busy, timeout;
    logic [3:0] obs;
    logic [3:0] want;
    logic prev_to = 1'b0;

    int passed = 0;
    int total = 0;
    logic [3:0] exp_q[$];

    assign obs = {gnt_a, gnt_b, busy, timeout};

    amifat_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .done_a  (done_a),
        .done_b  (done_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Invariant monitor: never both grants, never a two-cycle timeout.
    always @(negedge clk) begin
        if (rst) begin
            prev_to = 1'b0;
        end else begin
            total++;
            if ((gnt_a & gnt_b) !== 1'b0) $display("FAIL onehot: gnt_a=%b gnt_b=%b, required not both 1", gnt_a, gnt_b);
            else passed++;
            total++;
            if ((prev_to & timeout) !== 1'b0) $display("FAIL timeout_width: timeout high two cycles, required single pulse");
            else passed++;
            prev_to = timeout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        {req_a, req_b, done_a, done_b} = 4'b0000;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {req_a, req_b, done_a, done_b} = 4'b0000;
        tick();
        total++;
        if (obs !== E_IDLE) $display("FAIL reset_hold: got %b want %b", obs, E_IDLE);
        else passed++;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(E_IDLE);
            tick();
            want = exp_q.pop_front();
            total++;
            if (obs !== want || dut.state !== IDLE)
                $display("FAIL reset_idle c%0d: got %b state %0d want %b state 0", k, obs, dut.state, want);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [3:0] st [5];
        logic [3:0] ex [5];
        st = '{4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b0000};
        ex = '{E_GA, E_GA, E_GA, E_GAP, E_IDLE};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            {req_a, req_b, done_a, done_b} = st[k];
            exp_q.push_back(ex[k]);
            tick();
            want = exp_q.pop_front();
            total++;
            if (obs !== want) $display("FAIL single c%0d: got %b want %b", k + 1, obs, want);
            else passed++;
        end
    endtask

    task automatic test_alternate();
        logic [3:0] st [10];
        logic [3:0] ex [10];
        st = '{4'b1100, 4'b1100, 4'b1110, 4'b1100, 4'b1100,
               4'b1101, 4'b1100, 4'b1100, 4'b1110, 4'b1100};
        ex = '{E_GA, E_GA, E_GAP, E_GB, E_GB, E_GAP, E_GA, E_GA, E_GAP, E_GB};
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            {req_a, req_b, done_a, done_b} = st[k];
            exp_q.push_back(ex[k]);
            tick();
            want = exp_q.pop_front();
            total++;
            if (obs !== want) $display("FAIL alternate c%0d: got %b want %b", k + 1, obs, want);
            else passed++;
        end
    endtask

    task automatic test_max_hold();
        apply_reset();
        for (int k = 0; k < 19; k++) begin
            {req_a, req_b, done_a, done_b} = 4'b1100;
            if (k < 8) exp_q.push_back(E_GA);
            else if (k == 8) exp_q.push_back(E_TO);
            else if (k < 17) exp_q.push_back(E_GB);
            else if (k == 17) exp_q.push_back(E_TO);
            else exp_q.push_back(E_GA);
            tick();
            want = exp_q.pop_front();
            total++;
            if (obs !== want) $display("FAIL max_hold c%0d: got %b want %b", k + 1, obs, want);
            else passed++;
        end
    endtask

    task automatic test_late_other();
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            req_a = 1'b1;
            req_b = (k >= 15);
            {done_a, done_b} = 2'b00;
            if (k <= 14) exp_q.push_back(E_GA);
            else if (k == 15) exp_q.push_back(E_TO);
            else exp_q.push_back(E_GB);
            tick();
            want = exp_q.pop_front();
            total++;
            if (obs !== want) $display("FAIL late_other c%0d: got %b want %b", k + 1, obs, want);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            {req_a, req_b, done_a, done_b} = 4'b0100;
            exp_q.push_back(E_GB);
            tick();
            want = exp_q.pop_front();
            total++;
            if (obs !== want) $display("FAIL pre_reset_gb c%0d: got %b want %b", k + 1, obs, want);
            else passed++;
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== E_IDLE) $display("FAIL async_drop: got %b want %b", obs, E_IDLE);
        else passed++;
        {req_a, req_b} = 2'b11;
        tick();
        rst = 1'b0;
        exp_q.push_back(E_GA);
        tick();
        want = exp_q.pop_front();
        total++;
        if (obs !== want) $display("FAIL post_reset_a_first: got %b want %b", obs, want);
        else passed++;
        {req_a, req_b} = 2'b00;
        exp_q.push_back(E_GAP);
        tick();
        want = exp_q.pop_front();
        total++;
        if (obs !== want) $display("FAIL post_reset_release: got %b want %b", obs, want);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_max_hold();
        test_late_other();
        test_reset_mid_grant();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
